// File: rtl/sseg_mux_capture.sv
// Seven-segment scan snooper: watches a multiplexed display bus, waits for each
// digit's enable/segment pair to settle, then captures and decodes the glyph.
module sseg_mux_capture #(
    parameter int SETTLE = 16,
    parameter int TMO_W  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  en_led,
    input  logic [7:0]  sseg,
    input  logic        clr,
    output logic [63:0] pat,
    output logic [31:0] hex,
    output logic [7:0]  hex_ok,
    output logic [7:0]  seen,
    output logic        frame,
    output logic        mux_err,
    output logic        stalled
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPT, ST_HOLD} state_t;

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [15:0]      prev_q, prev_d;
    logic [7:0]       cap_en_q, cap_en_d;
    logic [63:0]      pat_q, pat_d;
    logic [31:0]      hex_q, hex_d;
    logic [7:0]       hex_ok_q, hex_ok_d;
    logic [7:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [2:0]       last_idx_q, last_idx_d;
    logic             have_last_q, have_last_d;

    logic [2:0]       idx;
    logic [4:0]       dec;

    // Exactly one enable driven low.
    function automatic logic one_low(input logic [7:0] e);
        logic [7:0] n;
        n = ~e;
        return (n != 8'd0) && ((n & (n - 8'd1)) == 8'd0);
    endfunction

    // Index of the lowest active-low enable.
    function automatic logic [2:0] low_idx(input logic [7:0] e);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (!e[i]) r = 3'(i);
        return r;
    endfunction

    // Returns {legal, nibble}; dp is not part of the glyph.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: return 5'h10;
            7'h79: return 5'h11;
            7'h24: return 5'h12;
            7'h30: return 5'h13;
            7'h19: return 5'h14;
            7'h12: return 5'h15;
            7'h02: return 5'h16;
            7'h78: return 5'h17;
            7'h00: return 5'h18;
            7'h10: return 5'h19;
            7'h08: return 5'h1A;
            7'h03: return 5'h1B;
            7'h46: return 5'h1C;
            7'h21: return 5'h1D;
            7'h06: return 5'h1E;
            7'h0E: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    // The captured value is the one that survived the settle window (prev_q),
    // so a change landing exactly in the CAPT cycle cannot leak in.
    assign idx = low_idx(prev_q[15:8]);
    assign dec = decode(prev_q[6:0]);

    // Next-state, capture and bookkeeping logic; clr overrides everything.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_d      = {en_led, sseg};
        cap_en_d    = cap_en_q;
        pat_d       = pat_q;
        hex_d       = hex_q;
        hex_ok_d    = hex_ok_q;
        seen_d      = seen_q;
        frame_d     = 1'b0;
        err_d       = err_q;
        tmo_d       = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
        last_idx_d  = last_idx_q;
        have_last_d = have_last_q;

        case (state_q)
            ST_IDLE: begin
                if (one_low(en_led)) begin
                    cnt_d   = 8'd1;
                    state_d = ST_SETTLE;
                end else if (en_led != 8'hFF) begin
                    // Multiple enables low while idle is also a mux fault.
                    err_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (en_led == 8'hFF) begin
                    state_d = ST_IDLE;
                end else if (!one_low(en_led)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if ({en_led, sseg} != prev_q) begin
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == SETTLE_C) state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                pat_d[int'(idx)*8 +: 8] = prev_q[7:0];
                hex_d[int'(idx)*4 +: 4] = dec[3:0];
                hex_ok_d[idx]           = dec[4];
                if (have_last_q && (idx <= last_idx_q)) begin
                    frame_d = 1'b1;
                    seen_d  = 8'd1 << idx;
                end else begin
                    seen_d[idx] = 1'b1;
                end
                last_idx_d  = idx;
                have_last_d = 1'b1;
                cap_en_d    = prev_q[15:8];
                tmo_d       = '0;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (en_led != cap_en_q) begin
                    if (en_led == 8'hFF) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr) begin
            state_d     = ST_IDLE;
            cnt_d       = 8'd0;
            pat_d       = '0;
            hex_d       = '0;
            hex_ok_d    = '0;
            seen_d      = '0;
            frame_d     = 1'b0;
            err_d       = 1'b0;
            tmo_d       = '0;
            have_last_d = 1'b0;
        end
    end

    // State and data registers; reset blanks the display copy (segments off).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            prev_q      <= '0;
            cap_en_q    <= 8'hFF;
            pat_q       <= '1;
            hex_q       <= '0;
            hex_ok_q    <= '0;
            seen_q      <= '0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            last_idx_q  <= '0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_q      <= prev_d;
            cap_en_q    <= cap_en_d;
            pat_q       <= pat_d;
            hex_q       <= hex_d;
            hex_ok_q    <= hex_ok_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            last_idx_q  <= last_idx_d;
            have_last_q <= have_last_d;
        end
    end

    assign pat     = pat_q;
    assign hex     = hex_q;
    assign hex_ok  = hex_ok_q;
    assign seen    = seen_q;
    assign frame   = frame_q;
    assign mux_err = err_q;
    assign stalled = &tmo_q;

endmodule

// File: tb/tb_sseg_mux_capture.sv
// Directed bench for sseg_mux_capture (SETTLE=16, TMO_W=6).
module tb_sseg_mux_capture;

    logic        clk;
    logic        reset_n;
    logic [7:0]  en_led;
    logic [7:0]  sseg;
    logic        clr;
    logic [63:0] pat;
    logic [31:0] hex;
    logic [7:0]  hex_ok;
    logic [7:0]  seen;
    logic        frame;
    logic        mux_err;
    logic        stalled;

    int n_chk  = 0;
    int n_pass = 0;
    int frame_cnt = 0;

    sseg_mux_capture #(.SETTLE(16), .TMO_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en_led  (en_led),
        .sseg    (sseg),
        .clr     (clr),
        .pat     (pat),
        .hex     (hex),
        .hex_ok  (hex_ok),
        .seen    (seen),
        .frame   (frame),
        .mux_err (mux_err),
        .stalled (stalled)
    );

    always #5 clk = ~clk;

    // Count frame pulses away from the active edge.
    always @(negedge clk) if (frame === 1'b1) frame_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; en_led = 8'hFF; sseg = 8'hFF; clr = 1'b0;
        step(2);
        chk("rst_pat",    pat, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_hex",    64'(hex), 64'h0);
        chk("rst_hex_ok", 64'(hex_ok), 64'h0);
        chk("rst_seen",   64'(seen), 64'h0);
        chk("rst_flags",  64'({frame, mux_err, stalled}), 64'h0);
        reset_n = 1'b1;
        step(1);

        // Basic capture, with exact latency.
        en_led = 8'hFE; sseg = 8'hC0;
        step(16);
        chk("basic_early", 64'(pat[7:0]), 64'hFF);
        step(1);
        chk("basic_pat",    64'(pat[7:0]), 64'hC0);
        chk("basic_hex",    64'(hex[3:0]), 64'h0);
        chk("basic_hex_ok", 64'(hex_ok[0]), 64'h1);
        chk("basic_seen",   64'(seen), 64'h01);
        step(3);

        // Glitch filter: segments never stable long enough.
        en_led = 8'hFD;
        for (int i = 0; i < 10; i++) begin
            sseg = (i % 2 == 0) ? 8'hF9 : 8'hA4;
            step(10);
        end
        chk("glitch_pat",  64'(pat[15:8]), 64'hFF);
        chk("glitch_seen", 64'(seen[1]), 64'h0);
        en_led = 8'hFF;
        step(2);

        // Illegal enables, then clear.
        en_led = 8'hFC;
        step(5);
        chk("illegal_err",  64'(mux_err), 64'h1);
        chk("illegal_pat",  64'(pat[15:0]), 64'hFFC0);
        chk("stall_before", 64'(stalled), 64'h1);
        en_led = 8'hFF; clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_err",   64'(mux_err), 64'h0);
        chk("clr_pat",   pat, 64'h0);
        chk("clr_seen",  64'(seen), 64'h0);
        chk("clr_stall", 64'(stalled), 64'h0);
        frame_cnt = 0;

        // Full scan, two passes over digits 0..3.
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 4; d++) begin
                en_led = ~(8'd1 << d);
                case (d)
                    0: sseg = 8'hC0;
                    1: sseg = 8'hF9;
                    2: sseg = 8'hA4;
                    default: sseg = 8'hB0;
                endcase
                step(17);
                if (p == 1 && d == 0) begin
                    chk("scan_frame_pulse", 64'(frame), 64'h1);
                    chk("scan_seen_wrap",   64'(seen), 64'h01);
                end
                step(15);
            end
            if (p == 0) chk("scan_pass1_frames", 64'(frame_cnt), 64'd0);
        end
        chk("scan_hex",    64'(hex), 64'h0000_3210);
        chk("scan_hex_ok", 64'(hex_ok), 64'h0F);
        chk("scan_pat",    pat, 64'h0000_0000_B0A4_F9C0);
        chk("scan_seen",   64'(seen), 64'h0F);
        chk("scan_frames", 64'(frame_cnt), 64'd1);

        // Bad glyph on digit 2, then timeout and recovery.
        en_led = 8'hFB; sseg = 8'hFF;
        step(17);
        chk("bad_hex_ok", 64'(hex_ok), 64'h0B);
        chk("bad_hex",    64'(hex[11:8]), 64'h0);
        chk("bad_pat",    64'(pat[23:16]), 64'hFF);
        chk("bad_seen",   64'(seen), 64'h04);
        en_led = 8'hFF;
        step(60);
        chk("tmo_not_yet", 64'(stalled), 64'h0);
        step(4);
        chk("tmo_stalled", 64'(stalled), 64'h1);
        en_led = 8'hFE; sseg = 8'hC0;
        step(17);
        chk("tmo_cleared", 64'(stalled), 64'h0);

        // Reset in the middle of a settle window.
        en_led = 8'hFD; sseg = 8'hF9;
        step(10);
        reset_n = 1'b0;
        step(3);
        chk("mid_rst_pat",   pat, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mid_rst_hex",   64'({hex, hex_ok, seen}), 64'h0);
        chk("mid_rst_flags", 64'({frame, mux_err, stalled}), 64'h0);
        reset_n = 1'b1;
        step(16);
        chk("post_rst_early", 64'(pat[15:8]), 64'hFF);
        step(1);
        chk("post_rst_pat",  64'(pat[15:8]), 64'hF9);
        chk("post_rst_hex",  64'(hex[7:4]), 64'h1);
        chk("post_rst_seen", 64'(seen), 64'h02);

        // clr during the CAPT cycle wins; next capture has no frame.
        en_led = 8'hFE; sseg = 8'hC0;
        step(16);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_capt_pat",  pat, 64'h0);
        chk("clr_capt_seen", 64'(seen), 64'h0);
        step(16);
        chk("recap_early", 64'(pat[7:0]), 64'h00);
        step(1);
        chk("recap_pat",   64'(pat[7:0]), 64'hC0);
        chk("recap_frame", 64'(frame), 64'h0);
        chk("recap_seen",  64'(seen), 64'h01);

        // Illegal enables coinciding with clr: clr wins.
        en_led = 8'hFF;
        step(2);
        en_led = 8'hFC; clr = 1'b1;
        step(1);
        chk("err_clr_same", 64'(mux_err), 64'h0);
        clr = 1'b0;
        step(1);
        chk("err_after_clr", 64'(mux_err), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
